// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module      : mult_div_pkg
// Description : Shared types for the iterative HI/LO multiply/divide unit:
//               operation encoding, controller states and a helper that
//               tells signed operations apart from unsigned ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic isSigned(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_cond_negate.sv
// ============================================================================
// Module      : cond_negate
// Description : Combinational two's-complement conditional negation.
//               o_val = i_neg ? -i_val : i_val
// Ports       : i_val [W-1:0]  value in
//               i_neg          negate when high
//               o_val [W-1:0]  value out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Radix-2 iterative multiply/divide unit for the HI/LO path.
//               One product/quotient bit per cycle on operand magnitudes,
//               sign fix-up in a final FIX cycle, registered hi/lo/divZero.
//               Optional macro MULT_DIV_EARLY_TERM_EN: multiplies finish as
//               soon as the remaining multiplier bits are all zero.
// Ports       : clk, reset (async, active-high)
//               start, op[1:0], a/b[BITS-1:0]    request
//               busy, done, divZero, hi/lo       status and results
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CNT_W = $clog2(BITS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            divZero,
  output logic [BITS-1:0] hi,
  output logic [BITS-1:0] lo
);

  state_t              r_state, w_next;
  op_t                 r_op;
  logic                r_sP, r_sR, r_bzero, r_done, r_divZero;
  logic [BITS-1:0]     r_opa, r_opb, r_hi, r_lo;
  logic [2*BITS-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;

  op_t                 w_op;
  logic                w_sgn, w_is_mul, w_last, w_early;
  logic [BITS-1:0]     w_a_mag, w_b_mag, w_quot, w_rem;
  logic [2*BITS-1:0]   w_prod;
  logic [BITS:0]       w_sum, w_shift, w_trial;
  logic [2*BITS-1:0]   w_mul_next, w_div_next, w_acc_next;

  assign w_op     = op_t'(op);
  assign w_sgn    = isSigned(w_op);
  assign w_is_mul = ~r_op[1];
  assign w_last   = (r_cnt == CNT_W'(BITS - 1));

  // Operand magnitudes for the unsigned core.
  cond_negate #(.W(BITS)) u_neg_a (.i_val(a), .i_neg(w_sgn & a[BITS-1]), .o_val(w_a_mag));
  cond_negate #(.W(BITS)) u_neg_b (.i_val(b), .i_neg(w_sgn & b[BITS-1]), .o_val(w_b_mag));

  // Sign fix-up; r_sP/r_sR are already zero for unsigned ops.
  cond_negate #(.W(2*BITS)) u_neg_p (.i_val(r_acc), .i_neg(r_sP), .o_val(w_prod));
  cond_negate #(.W(BITS)) u_neg_q (.i_val(r_acc[BITS-1:0]), .i_neg(r_sP), .o_val(w_quot));
  cond_negate #(.W(BITS)) u_neg_r (.i_val(r_acc[2*BITS-1:BITS]), .i_neg(r_sR), .o_val(w_rem));

`ifdef MULT_DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] w_left;
  assign w_left  = CNT_W'(BITS - 1) - r_cnt;
  assign w_early = w_is_mul && (r_opb[BITS-1:1] == '0);
`else
  assign w_early = 1'b0;
`endif

  // One iteration step. Multiply: r_acc = {upper accumulator, shifted-in
  // product bits}; the add carry lands in the msb of the shifted result.
  // Divide: r_acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*BITS-1:BITS]} + (r_opb[0] ? {1'b0, r_opa} : '0);
    w_mul_next = {w_sum, r_acc[BITS-1:1]};
`ifdef MULT_DIV_EARLY_TERM_EN
    // Skip the remaining all-zero multiplier bits by applying their shifts now.
    if (w_early) begin
      w_mul_next = w_mul_next >> w_left;
    end
`endif
    w_shift    = {r_acc[2*BITS-1:BITS], r_acc[BITS-1]};
    w_trial    = w_shift - {1'b0, r_opb};
    w_div_next = w_trial[BITS] ? {w_shift[BITS-1:0], r_acc[BITS-2:0], 1'b0}
                               : {w_trial[BITS-1:0], r_acc[BITS-2:0], 1'b1};
    w_acc_next = w_is_mul ? w_mul_next : w_div_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last || w_early) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= OP_MULT;
      r_sP      <= 1'b0;
      r_sR      <= 1'b0;
      r_bzero   <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= w_op;
            r_opa   <= w_a_mag;
            r_opb   <= w_b_mag;
            r_sP    <= w_sgn & (a[BITS-1] ^ b[BITS-1]);
            r_sR    <= w_sgn & a[BITS-1];
            r_bzero <= (b == '0);
            // Divide starts with the dividend magnitude in the quotient half.
            r_acc   <= w_op[1] ? {{BITS{1'b0}}, w_a_mag} : '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_mul) begin
            r_opb <= r_opb >> 1;
          end
        end
        FIX: begin
          if (w_is_mul) begin
            {r_hi, r_lo} <= w_prod;
            r_divZero    <= 1'b0;
          end else begin
            // A zero divisor leaves |a| in the remainder, so the sign fix-up
            // restores the original a; only the quotient needs overriding.
            r_hi      <= w_rem;
            r_lo      <= r_bzero ? '1 : w_quot;
            r_divZero <= r_bzero;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign divZero = r_divZero;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

`default_nettype wire
